// File: rtl/rtc_reg_bank_streamer.sv
// Double-buffered RTC snapshot bank: captures NUM_REGS words into a shadow bank, commits them
// atomically between output frames, streams the active bank as framed words and serves random reads.
module rtc_reg_bank_streamer #(
    parameter int DATA_W    = 8,
    parameter int NUM_REGS  = 11,
    parameter int IDX_W     = 4,
    parameter int FRAME_GAP = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cap_start,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              stream_en,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_first,
    output logic              out_last,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              data_new,
    output logic              cap_overrun
);

    localparam int                DEPTH    = 2 ** IDX_W;
    localparam int                GAP_W    = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0]  NUM_IDX  = IDX_W'(NUM_REGS);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(FRAME_GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_STREAM
    } state_t;

    // Banks span the full index space so every IDX_W address maps to a real entry;
    // entries at or above NUM_REGS stay zero.
    logic [DATA_W-1:0] r_shadow [DEPTH];
    logic [DATA_W-1:0] r_active [DEPTH];

    logic [IDX_W-1:0]  r_cap_idx;
    logic              r_commit_pend;
    logic              r_data_new;
    logic              r_cap_overrun;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_out_idx;
    logic [IDX_W-1:0]  w_out_idx_nxt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [GAP_W-1:0]  w_gap_cnt_nxt;

    logic [IDX_W-1:0]  w_cap_base;
    logic              w_cap_wr;
    logic              w_cap_drop;
    logic              w_commit;

    assign w_cap_base = cap_start ? '0 : r_cap_idx;
    // A pending snapshot blocks all writes, including a restart, so it can never be overwritten.
    assign w_cap_wr   = cap_valid && (w_cap_base < NUM_IDX) && !r_commit_pend;
    assign w_cap_drop = cap_valid && !w_cap_wr;
    assign w_commit   = r_commit_pend && (r_state != S_STREAM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_shadow[IDX_W'(i)] <= '0;
                r_active[IDX_W'(i)] <= '0;
            end
            r_cap_idx     <= '0;
            r_commit_pend <= 1'b0;
            r_data_new    <= 1'b0;
            r_cap_overrun <= 1'b0;
        end else begin
            if (w_cap_wr) begin
                r_shadow[w_cap_base] <= data_in;
                r_cap_idx            <= w_cap_base + IDX_W'(1);
            end else if (cap_start) begin
                r_cap_idx <= '0;
            end

            if (w_cap_drop) begin
                r_cap_overrun <= 1'b1;
            end else if (cap_start) begin
                r_cap_overrun <= 1'b0;
            end

            if (w_commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_active[IDX_W'(i)] <= r_shadow[IDX_W'(i)];
                end
                r_commit_pend <= 1'b0;
            end else if (w_cap_wr && (w_cap_base == LAST_IDX)) begin
                r_commit_pend <= 1'b1;
            end

            r_data_new <= w_commit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_out_idx <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_idx <= w_out_idx_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_out_idx_nxt = r_out_idx;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (stream_en) begin
                    w_state_nxt   = S_GAP;
                    w_gap_cnt_nxt = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (!stream_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_state_nxt   = S_STREAM;
                    w_out_idx_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                end
            end
            S_STREAM: begin
                // stream_en is only sampled at frame end, so a frame is never truncated.
                if (out_ready) begin
                    if (r_out_idx == LAST_IDX) begin
                        w_out_idx_nxt = '0;
                        w_gap_cnt_nxt = GAP_LOAD;
                        w_state_nxt   = stream_en ? S_GAP : S_IDLE;
                    end else begin
                        w_out_idx_nxt = r_out_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign out_valid   = (r_state == S_STREAM);
    assign out_data    = r_active[r_out_idx];
    assign out_idx     = r_out_idx;
    assign out_first   = out_valid && (r_out_idx == '0);
    assign out_last    = out_valid && (r_out_idx == LAST_IDX);
    assign rd_data     = (rd_addr < NUM_IDX) ? r_active[rd_addr] : '0;
    assign data_new    = r_data_new;
    assign cap_overrun = r_cap_overrun;

endmodule

// File: tb/tb_rtc_reg_bank_streamer.sv
// Randomized bench for rtc_reg_bank_streamer: two instances (default and 16b/4-reg/no-gap)
// driven by identical stimulus and compared every cycle against a snapshot/frame reference model.
module tb_rtc_reg_bank_streamer;

    logic        clk;
    logic        reset;
    logic        cap_start;
    logic        cap_valid;
    logic [15:0] d16;
    logic        stream_en;
    logic        out_ready;
    logic [3:0]  rd_addr;

    logic        o1_valid, o1_first, o1_last, o1_dnew, o1_ovr;
    logic [7:0]  o1_data, o1_rd;
    logic [3:0]  o1_idx;
    logic        o2_valid, o2_first, o2_last, o2_dnew, o2_ovr;
    logic [15:0] o2_data, o2_rd;
    logic [3:0]  o2_idx;

    int n_checks;
    int n_errors;

    rtc_reg_bank_streamer u_dut1 (
        .clk(clk), .reset(reset), .cap_start(cap_start), .cap_valid(cap_valid),
        .data_in(d16[7:0]), .stream_en(stream_en), .out_ready(out_ready),
        .out_valid(o1_valid), .out_data(o1_data), .out_idx(o1_idx),
        .out_first(o1_first), .out_last(o1_last), .rd_addr(rd_addr), .rd_data(o1_rd),
        .data_new(o1_dnew), .cap_overrun(o1_ovr)
    );

    rtc_reg_bank_streamer #(.DATA_W(16), .NUM_REGS(4), .IDX_W(4), .FRAME_GAP(0)) u_dut2 (
        .clk(clk), .reset(reset), .cap_start(cap_start), .cap_valid(cap_valid),
        .data_in(d16), .stream_en(stream_en), .out_ready(out_ready),
        .out_valid(o2_valid), .out_data(o2_data), .out_idx(o2_idx),
        .out_first(o2_first), .out_last(o2_last), .rd_addr(rd_addr), .rd_data(o2_rd),
        .data_new(o2_dnew), .cap_overrun(o2_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: per-instance snapshot arrays plus a frame scheduler.
    // phase: 0 idle, 1 waiting out the inter-frame gap, 2 delivering a frame.
    int m_sh   [2][16];
    int m_act  [2][16];
    int m_fill [2];
    bit m_pend [2];
    bit m_ovr  [2];
    bit m_dnew [2];
    int m_phase[2];
    int m_left [2];
    int m_pos  [2];

    function automatic int nregs(input int k);
        return (k == 0) ? 11 : 4;
    endfunction

    function automatic int fgap(input int k);
        return (k == 0) ? 22 : 0;
    endfunction

    function automatic int word_of(input int k);
        return (k == 0) ? int'(d16[7:0]) : int'(d16);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                m_sh[k][i]  = 0;
                m_act[k][i] = 0;
            end
            m_fill[k] = 0; m_pend[k] = 0; m_ovr[k] = 0; m_dnew[k] = 0;
            m_phase[k] = 0; m_left[k] = 0; m_pos[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int  n;
        int  slot;
        bit  take;
        bit  publish;
        n       = nregs(k);
        slot    = cap_start ? 0 : m_fill[k];
        take    = cap_valid && (slot < n) && !m_pend[k];
        publish = m_pend[k] && (m_phase[k] != 2);

        if (publish) begin
            for (int i = 0; i < n; i++) m_act[k][i] = m_sh[k][i];
            m_pend[k] = 0;
        end
        if (take) begin
            m_sh[k][slot] = word_of(k);
            m_fill[k]     = slot + 1;
            if (slot + 1 == n) m_pend[k] = 1;
        end else if (cap_start) begin
            m_fill[k] = 0;
        end
        if (cap_valid && !take) m_ovr[k] = 1;
        else if (cap_start)     m_ovr[k] = 0;
        m_dnew[k] = publish;

        if (m_phase[k] == 0) begin
            if (stream_en) begin
                m_phase[k] = 1;
                m_left[k]  = fgap(k) + 1;
            end
        end else if (m_phase[k] == 1) begin
            if (!stream_en) m_phase[k] = 0;
            else if (m_left[k] == 1) begin
                m_phase[k] = 2;
                m_pos[k]   = 0;
            end else m_left[k]--;
        end else if (out_ready) begin
            if (m_pos[k] == n - 1) begin
                m_pos[k]   = 0;
                m_phase[k] = stream_en ? 1 : 0;
                m_left[k]  = fgap(k) + 1;
            end else m_pos[k]++;
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] gv, gd, gi, gf, gl, gr, gn, go;
            int n;
            int er;
            bit ev;
            n  = nregs(k);
            ev = (m_phase[k] == 2);
            er = (int'(rd_addr) < n) ? m_act[k][rd_addr] : 0;
            if (k == 0) begin
                gv = 32'(o1_valid); gd = 32'(o1_data); gi = 32'(o1_idx); gf = 32'(o1_first);
                gl = 32'(o1_last);  gr = 32'(o1_rd);   gn = 32'(o1_dnew); go = 32'(o1_ovr);
            end else begin
                gv = 32'(o2_valid); gd = 32'(o2_data); gi = 32'(o2_idx); gf = 32'(o2_first);
                gl = 32'(o2_last);  gr = 32'(o2_rd);   gn = 32'(o2_dnew); go = 32'(o2_ovr);
            end
            check($sformatf("u%0d.out_valid", k), gv, 32'(ev));
            check($sformatf("u%0d.out_data", k), gd, 32'(m_act[k][m_pos[k]]));
            check($sformatf("u%0d.out_idx", k), gi, 32'(m_pos[k]));
            check($sformatf("u%0d.out_first", k), gf, 32'(ev && m_pos[k] == 0));
            check($sformatf("u%0d.out_last", k), gl, 32'(ev && m_pos[k] == n - 1));
            check($sformatf("u%0d.rd_data", k), gr, 32'(er));
            check($sformatf("u%0d.data_new", k), gn, 32'(m_dnew[k]));
            check($sformatf("u%0d.cap_overrun", k), go, 32'(m_ovr[k]));
        end
    endtask

    task automatic tick();
        rd_addr = 4'($urandom_range(0, 15));
        @(posedge clk);
        if (!reset) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
        #1;
        compare_all();
    endtask

    task automatic cap_word(input bit start, input logic [7:0] b);
        cap_start = start;
        cap_valid = 1'b1;
        d16       = {8'($urandom), b};
        tick();
        cap_start = 1'b0;
        cap_valid = 1'b0;
    endtask

    // kind 0: first instance streaming word v; kind 1: first instance in gap with v cycles left;
    // kind 2: no snapshot pending on either instance.
    task automatic wait_cond(input int kind, input int v, input int budget);
        int  cnt;
        bit  hit;
        cnt = 0;
        hit = 0;
        while (!hit && cnt < budget) begin
            case (kind)
                0:       hit = (m_phase[0] == 2) && (m_pos[0] == v);
                1:       hit = (m_phase[0] == 1) && (m_left[0] == v);
                default: hit = !m_pend[0] && !m_pend[1];
            endcase
            if (!hit) begin
                tick();
                cnt++;
            end
        end
        if (!hit) check($sformatf("wait_timeout_k%0d", kind), 32'(cnt), 32'(budget + 1));
    endtask

    initial begin
        int  lat1, lat2, cnt;
        bit  have_hi;
        logic [3:0] frame_hi;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        cap_start = 1'b0;
        cap_valid = 1'b0;
        d16       = '0;
        stream_en = 1'b0;
        out_ready = 1'b1;
        rd_addr   = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Snapshot 0x11..0x1B, then enable streaming and measure start-up latency.
        for (int i = 0; i < 11; i++) cap_word(i == 0, 8'(8'h11 + i));
        repeat (3) tick();
        stream_en = 1'b1;
        lat1 = 0; lat2 = 0; cnt = 0;
        while ((lat1 == 0 || lat2 == 0) && cnt < 100) begin
            tick();
            cnt++;
            if (o1_valid && lat1 == 0) lat1 = cnt;
            if (o2_valid && lat2 == 0) lat2 = cnt;
        end
        check("latency_u0", 32'(lat1), 32'(24));
        check("latency_u1", 32'(lat2), 32'(2));
        repeat (60) tick();

        // Second snapshot finishing mid-frame must not leak into that frame.
        wait_cond(1, 6, 200);
        for (int i = 0; i < 11; i++) cap_word(i == 0, 8'(8'h21 + i));
        have_hi  = 0;
        frame_hi = '0;
        repeat (70) begin
            tick();
            if (o1_valid && o1_first) begin
                frame_hi = o1_data[7:4];
                have_hi  = 1;
            end else if (o1_valid && have_hi) begin
                check("frame_mix", 32'(o1_data[7:4]), 32'(frame_hi));
            end
        end

        // Twelve words after one start: the twelfth is dropped.
        wait_cond(2, 0, 200);
        for (int i = 0; i < 12; i++) cap_word(i == 0, 8'(8'h31 + i));
        check("overrun_set_u0", 32'(o1_ovr), 32'(1));
        check("overrun_set_u1", 32'(o2_ovr), 32'(1));
        cap_start = 1'b1;
        tick();
        cap_start = 1'b0;
        check("overrun_clr_u0", 32'(o1_ovr), 32'(0));

        // Backpressure 1,0,0,1 while streaming.
        wait_cond(0, 2, 300);
        out_ready = 1'b1; tick();
        check("bp_idx_a", 32'(o1_idx), 32'(3));
        out_ready = 1'b0; tick();
        check("bp_idx_b", 32'(o1_idx), 32'(3));
        tick();
        check("bp_idx_c", 32'(o1_idx), 32'(3));
        out_ready = 1'b1; tick();
        check("bp_idx_d", 32'(o1_idx), 32'(4));

        // stream_en dropped mid-frame: frame completes, then idle.
        wait_cond(0, 3, 300);
        stream_en = 1'b0;
        repeat (12) tick();
        check("stop_idle_valid", 32'(o1_valid), 32'(0));
        stream_en = 1'b1;

        // Random traffic.
        repeat (1500) begin
            cap_start = ($urandom_range(0, 39) == 0);
            cap_valid = $urandom_range(0, 1) == 1;
            d16       = 16'($urandom);
            stream_en = ($urandom_range(0, 49) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cap_start = 1'b0;
        cap_valid = 1'b0;
        stream_en = 1'b1;
        out_ready = 1'b1;

        // Asynchronous reset mid-frame with a partial snapshot in the shadow bank.
        wait_cond(1, 20, 300);
        for (int i = 0; i < 6; i++) cap_word(i == 0, 8'(8'h41 + i));
        wait_cond(0, 5, 300);
        rd_addr = '0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("areset_valid", 32'(o1_valid), 32'(0));
        check("areset_rd0", 32'(o1_rd), 32'(0));
        check("areset_ovr", 32'(o1_ovr), 32'(0));
        compare_all();
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cap_word(i == 0, 8'(8'h51 + i));
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
